fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/async_fifo_pkg.sv | 15 +
 rtl/rr_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared state type and parameter limits for the FIFO write arbiter
package async_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int N_REQ_MIN     = 2;
    localparam int N_REQ_MAX     = 8;
    localparam int MAX_BURST_MIN = 1;
    localparam int MAX_BURST_MAX = 16;
    localparam int BEAT_CNT_W    = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick of the first request after last_i
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        // Walk from farthest to nearest so the requester closest after last_i overwrites last.
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % N);
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter merging requesters onto one FIFO write port
module fifo_write_arbiter
    import async_fifo_pkg::*;
#(
    parameter int  BITS      = 32,
    parameter int  N_REQ     = 4,
    parameter int  MAX_BURST = 4,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           p_req_valid,
    input  logic [N_REQ-1:0][BITS-1:0] p_req_data,
    input  logic [N_REQ-1:0]           p_req_last,
    output logic [N_REQ-1:0]           p_req_ready,
    output logic                       p_fifo_write_en,
    output logic [BITS-1:0]            p_fifo_write_data,
    input  logic                       p_fifo_write_full,
    output logic                       p_grant_valid,
    output logic [IDW-1:0]             p_grant_id
);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $fatal(1, "fifo_write_arbiter: N_REQ out of range");
    end
    if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX) begin : g_bad_max_burst
        $fatal(1, "fifo_write_arbiter: MAX_BURST out of range");
    end

    arb_state_t            state_q, state_d;
    logic                  grant_valid_q, grant_valid_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic [IDW-1:0]        last_grant_q, last_grant_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_CNT_W:0]   beat_cnt_inc;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_found;
    logic                  in_burst;
    logic                  beat_accept;
    logic                  burst_done;

    rr_pick #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_rr_pick (
        .req_i   (p_req_valid),
        .last_i  (last_grant_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign in_burst     = (state_q == BURST);
    assign beat_accept  = in_burst && p_req_valid[grant_id_q] && !p_fifo_write_full;
    // One extra bit so MAX_BURST = 16 is reachable with a 4-bit counter.
    assign beat_cnt_inc = {1'b0, beat_cnt_q} + (BEAT_CNT_W + 1)'(1);
    assign burst_done   = beat_accept &&
                          (p_req_last[grant_id_q] || beat_cnt_inc == (BEAT_CNT_W + 1)'(MAX_BURST));

    always_comb begin
        p_req_ready = '0;
        if (in_burst && !p_fifo_write_full) begin
            p_req_ready[grant_id_q] = 1'b1;
        end
    end

    assign p_fifo_write_en   = beat_accept;
    assign p_fifo_write_data = p_req_data[grant_id_q];
    assign p_grant_valid     = grant_valid_q;
    assign p_grant_id        = grant_id_q;

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = BURST;
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_idx;
                    beat_cnt_d    = '0;
                end
            end
            BURST: begin
                if (beat_accept) begin
                    beat_cnt_d = beat_cnt_inc[BEAT_CNT_W-1:0];
                end
                if (burst_done) begin
                    state_d       = IDLE;
                    grant_valid_d = 1'b0;
                    last_grant_d  = grant_id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= IDW'(N_REQ - 1);
            beat_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            beat_cnt_q    <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int BITS      = 32;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [N_REQ-1:0]           p_req_valid;
    logic [N_REQ-1:0][BITS-1:0] p_req_data;
    logic [N_REQ-1:0]           p_req_last;
    logic [N_REQ-1:0]           p_req_ready;
    logic                       p_fifo_write_en;
    logic [BITS-1:0]            p_fifo_write_data;
    logic                       p_fifo_write_full;
    logic                       p_grant_valid;
    logic [IDW-1:0]             p_grant_id;

    int checks = 0;
    int errors = 0;

    logic [BITS:0]    src_q[N_REQ][$];
    logic [BITS-1:0]  sent_q[N_REQ][$];
    logic [BITS-1:0]  got_q[N_REQ][$];
    int unsigned      seq_q[N_REQ];
    logic [N_REQ-1:0] allow;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .BITS      (BITS),
        .N_REQ     (N_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .p_req_valid       (p_req_valid),
        .p_req_data        (p_req_data),
        .p_req_last        (p_req_last),
        .p_req_ready       (p_req_ready),
        .p_fifo_write_en   (p_fifo_write_en),
        .p_fifo_write_data (p_fifo_write_data),
        .p_fifo_write_full (p_fifo_write_full),
        .p_grant_valid     (p_grant_valid),
        .p_grant_id        (p_grant_id)
    );

    task automatic load_packet(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            logic [BITS-1:0] d;
            logic            l;
            d = {8'(r), 24'(seq_q[r])};
            l = (b == len - 1);
            seq_q[r]++;
            src_q[r].push_back({l, d});
            sent_q[r].push_back(d);
        end
    endtask

    task automatic drive();
        for (int r = 0; r < N_REQ; r++) begin
            logic [BITS:0] e;
            if (src_q[r].size() > 0 && allow[r]) begin
                e              = src_q[r][0];
                p_req_valid[r] = 1'b1;
                p_req_data[r]  = e[BITS-1:0];
                p_req_last[r]  = e[BITS];
            end else begin
                p_req_valid[r] = 1'b0;
                p_req_data[r]  = '0;
                p_req_last[r]  = 1'b0;
            end
        end
    endtask

    task automatic finish_cycle();
        logic [N_REQ-1:0] acc;
        acc = p_req_valid & p_req_ready;
        @(posedge clk);
        if (!rst) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (acc[r]) void'(src_q[r].pop_front());
            end
        end
    endtask

    task automatic apply_reset();
        rst               = 1'b1;
        p_fifo_write_full = 1'b0;
        allow             = '1;
        p_req_valid       = '0;
        p_req_data        = '0;
        p_req_last        = '0;
        for (int r = 0; r < N_REQ; r++) begin
            src_q[r].delete();
            sent_q[r].delete();
            got_q[r].delete();
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        p_fifo_write_full = 1'b0;
        p_req_valid       = '1;
        p_req_last        = '0;
        p_req_data        = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (p_req_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_ready: got %b expected 0000", p_req_ready);
            end
            checks++;
            if (p_fifo_write_en !== 1'b0) begin
                errors++; $display("FAIL reset_wen: got %b expected 0", p_fifo_write_en);
            end
            checks++;
            if (p_grant_valid !== 1'b0) begin
                errors++; $display("FAIL reset_gv: got %b expected 0", p_grant_valid);
            end
            checks++;
            if (p_grant_id !== 2'd0) begin
                errors++; $display("FAIL reset_gid: got %0d expected 0", p_grant_id);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        load_packet(1, 3);
        for (int c = 0; c < 6; c++) begin
            logic exp_on;
            @(negedge clk);
            drive();
            #1;
            exp_on = (c >= 1 && c <= 3);
            checks++;
            if (p_grant_valid !== exp_on) begin
                errors++; $display("FAIL single_gv c%0d: got %b expected %b", c, p_grant_valid, exp_on);
            end
            checks++;
            if (p_fifo_write_en !== exp_on) begin
                errors++; $display("FAIL single_wen c%0d: got %b expected %b", c, p_fifo_write_en, exp_on);
            end
            if (exp_on) begin
                checks++;
                if (p_grant_id !== 2'd1) begin
                    errors++; $display("FAIL single_gid c%0d: got %0d expected 1", c, p_grant_id);
                end
                checks++;
                if (p_fifo_write_data !== sent_q[1][c-1]) begin
                    errors++; $display("FAIL single_data c%0d: got %h expected %h", c, p_fifo_write_data, sent_q[1][c-1]);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_rr_order();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < N_REQ; r++) load_packet(r, 1);
        end
        for (int c = 0; c < 10; c++) begin
            logic             exp_on;
            int               exp_g;
            logic [N_REQ-1:0] exp_ready;
            @(negedge clk);
            drive();
            #1;
            exp_on    = (c % 2 == 1);
            exp_g     = ((c - 1) / 2) % N_REQ;
            exp_ready = '0;
            if (exp_on) exp_ready[exp_g] = 1'b1;
            checks++;
            if (p_grant_valid !== exp_on) begin
                errors++; $display("FAIL rr_gv c%0d: got %b expected %b", c, p_grant_valid, exp_on);
            end
            checks++;
            if (p_req_ready !== exp_ready) begin
                errors++; $display("FAIL rr_ready c%0d: got %b expected %b", c, p_req_ready, exp_ready);
            end
            if (exp_on) begin
                checks++;
                if (p_grant_id !== IDW'(exp_g)) begin
                    errors++; $display("FAIL rr_gid c%0d: got %0d expected %0d", c, p_grant_id, exp_g);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_split();
        int burst_g[4]   = '{2, 3, 2, 2};
        int burst_len[4] = '{4, 3, 4, 2};
        int ptr[N_REQ];
        apply_reset();
        load_packet(2, 10);
        load_packet(3, 3);
        for (int r = 0; r < N_REQ; r++) ptr[r] = 0;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c <= burst_len[b]; c++) begin
                int g;
                g = burst_g[b];
                @(negedge clk);
                drive();
                #1;
                checks++;
                if (p_grant_valid !== (c != 0)) begin
                    errors++; $display("FAIL split_gv b%0d c%0d: got %b expected %b", b, c, p_grant_valid, c != 0);
                end
                checks++;
                if (p_fifo_write_en !== (c != 0)) begin
                    errors++; $display("FAIL split_wen b%0d c%0d: got %b expected %b", b, c, p_fifo_write_en, c != 0);
                end
                if (c != 0) begin
                    checks++;
                    if (p_grant_id !== IDW'(g)) begin
                        errors++; $display("FAIL split_gid b%0d c%0d: got %0d expected %0d", b, c, p_grant_id, g);
                    end
                    checks++;
                    if (p_fifo_write_data !== sent_q[g][ptr[g]]) begin
                        errors++; $display("FAIL split_data b%0d c%0d: got %h expected %h", b, c, p_fifo_write_data, sent_q[g][ptr[g]]);
                    end
                    ptr[g]++;
                end
                finish_cycle();
            end
        end
    endtask

    task automatic test_full_stall();
        int ptr[2] = '{0, 0};
        apply_reset();
        load_packet(0, 6);
        load_packet(1, 2);
        for (int c = 0; c < 12; c++) begin
            logic             stall, exp_gv, exp_wen;
            int               g;
            logic [N_REQ-1:0] exp_ready;
            @(negedge clk);
            stall             = (c >= 3 && c <= 7);
            p_fifo_write_full = stall;
            drive();
            #1;
            exp_gv    = (c >= 1 && c <= 9) || c == 11;
            g         = (c <= 9) ? 0 : 1;
            exp_wen   = exp_gv && !stall;
            exp_ready = '0;
            if (exp_wen) exp_ready[g] = 1'b1;
            checks++;
            if (p_grant_valid !== exp_gv) begin
                errors++; $display("FAIL full_gv c%0d: got %b expected %b", c, p_grant_valid, exp_gv);
            end
            checks++;
            if (p_fifo_write_en !== exp_wen) begin
                errors++; $display("FAIL full_wen c%0d: got %b expected %b", c, p_fifo_write_en, exp_wen);
            end
            checks++;
            if (p_req_ready !== exp_ready) begin
                errors++; $display("FAIL full_ready c%0d: got %b expected %b", c, p_req_ready, exp_ready);
            end
            if (exp_wen) begin
                checks++;
                if (p_fifo_write_data !== sent_q[g][ptr[g]]) begin
                    errors++; $display("FAIL full_data c%0d: got %h expected %h", c, p_fifo_write_data, sent_q[g][ptr[g]]);
                end
                ptr[g]++;
            end
            finish_cycle();
        end
        p_fifo_write_full = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_packet(3, 6);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive();
            #1;
            finish_cycle();
        end
        @(negedge clk);
        drive();
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (p_req_ready !== 4'b0000 || p_fifo_write_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_out: got ready %b wen %b expected 0000 0", p_req_ready, p_fifo_write_en);
        end
        checks++;
        if (p_grant_valid !== 1'b0 || p_grant_id !== 2'd0) begin
            errors++; $display("FAIL rstmid_grant: got gv %b gid %0d expected 0 0", p_grant_valid, p_grant_id);
        end
        finish_cycle();
        checks++;
        if (src_q[3].size() != 4) begin
            errors++; $display("FAIL rstmid_consumed: got %0d beats left expected 4", src_q[3].size());
        end
        @(negedge clk);
        rst = 1'b0;
        load_packet(0, 1);
        drive();
        #1;
        checks++;
        if (p_grant_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got %b expected 0", p_grant_valid);
        end
        finish_cycle();
        @(negedge clk);
        drive();
        #1;
        checks++;
        if (p_grant_valid !== 1'b1 || p_grant_id !== 2'd0) begin
            errors++; $display("FAIL rstmid_regrant: got gv %b gid %0d expected 1 0", p_grant_valid, p_grant_id);
        end
        checks++;
        if (p_fifo_write_en !== 1'b1 || p_fifo_write_data !== sent_q[0][0]) begin
            errors++; $display("FAIL rstmid_write: got wen %b data %h expected 1 %h", p_fifo_write_en, p_fifo_write_data, sent_q[0][0]);
        end
        finish_cycle();
    endtask

    task automatic test_random();
        bit               m_busy = 1'b0;
        int               m_g    = 0;
        int               m_cnt  = 0;
        int               m_last = N_REQ - 1;
        int               cyc    = 0;
        logic             exp_wen;
        logic [N_REQ-1:0] exp_ready;
        apply_reset();
        for (int r = 0; r < N_REQ; r++) begin
            for (int p = 0; p < 4; p++) load_packet(r, $urandom_range(1, 10));
        end
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) > 0 && cyc < 3000) begin
            @(negedge clk);
            for (int r = 0; r < N_REQ; r++) allow[r] = ($urandom_range(0, 3) != 0);
            p_fifo_write_full = ($urandom_range(0, 4) == 0);
            drive();
            #1;
            exp_wen   = m_busy && p_req_valid[m_g] && !p_fifo_write_full;
            exp_ready = '0;
            if (m_busy && !p_fifo_write_full) exp_ready[m_g] = 1'b1;
            checks++;
            if (p_grant_valid !== m_busy) begin
                errors++; $display("FAIL rand_gv cyc%0d: got %b expected %b", cyc, p_grant_valid, m_busy);
            end
            if (m_busy) begin
                checks++;
                if (p_grant_id !== IDW'(m_g)) begin
                    errors++; $display("FAIL rand_gid cyc%0d: got %0d expected %0d", cyc, p_grant_id, m_g);
                end
            end
            checks++;
            if (p_req_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, p_req_ready, exp_ready);
            end
            checks++;
            if (p_fifo_write_en !== exp_wen) begin
                errors++; $display("FAIL rand_wen cyc%0d: got %b expected %b", cyc, p_fifo_write_en, exp_wen);
            end
            if (p_fifo_write_en === 1'b1) got_q[p_grant_id].push_back(p_fifo_write_data);
            if (!m_busy) begin
                bit found = 1'b0;
                for (int k = 1; k <= N_REQ; k++) begin
                    int r;
                    r = (m_last + k) % N_REQ;
                    if (!found && p_req_valid[r]) begin
                        found  = 1'b1;
                        m_busy = 1'b1;
                        m_g    = r;
                        m_cnt  = 0;
                    end
                end
            end else if (exp_wen) begin
                m_cnt++;
                if (p_req_last[m_g] || m_cnt == MAX_BURST) begin
                    m_busy = 1'b0;
                    m_last = m_g;
                end
            end
            finish_cycle();
            cyc++;
        end
        p_fifo_write_full = 1'b0;
        checks++;
        if (cyc >= 3000) begin
            errors++; $display("FAIL rand_drain: got timeout after %0d cycles expected all sources drained", cyc);
        end
        for (int r = 0; r < N_REQ; r++) begin
            int bad;
            bad = (got_q[r].size() != sent_q[r].size()) ? 1 : 0;
            for (int i = 0; i < got_q[r].size() && i < sent_q[r].size(); i++) begin
                if (got_q[r][i] !== sent_q[r][i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand_order req%0d: got %0d beats (%0d bad) expected %0d in order", r, got_q[r].size(), bad, sent_q[r].size());
            end
        end
    endtask

    initial begin
        for (int r = 0; r < N_REQ; r++) seq_q[r] = 0;
        allow = '1;
        test_reset();
        test_single();
        test_rr_order();
        test_split();
        test_full_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
